ppu_vscan: RTL and testbench

// Video buffer scan-out: the read side of the frame buffer that the PPU render engine writes.

---
 rtl/ppu_vscan.sv | 112 +++++++++++
 tb/tb_ppu_vscan.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vscan.sv
// VGA scan-out for the PPU frame buffer: 640x480 timing, 2x-scaled 256x240 window,
// three-stage fetch pipeline and double-buffer bank ownership.
module ppu_vscan #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter int          H_OFS    = 64,
    parameter logic [7:0]  BORDER   = 8'h0F
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_pix_ce,
    input  logic        i_wr_done,
    output logic        o_wr_bank,
    output logic        o_vblank,
    output logic [16:0] o_vbuf_raddr,
    input  logic [7:0]  i_vbuf_rdata,
    output logic [7:0]  o_pix,
    output logic        o_de,
    output logic        o_hsync,
    output logic        o_vsync
);

    localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] WIN_BEG = 10'(H_OFS);
    localparam logic [9:0] WIN_END = 10'(H_OFS + 512);

    logic [9:0] r_h, r_v;
    logic [9:0] h_nxt, v_nxt;
    logic       h_wrap, vbl_set, vbl_clr, swap;
    logic       win, de0, hs0, vs0;
    logic       r_rd_bank, r_pend;
    logic       s1_win, s1_de, s1_hs, s1_vs;

    always_comb begin
        h_wrap  = (r_h == H_LAST);
        h_nxt   = h_wrap ? 10'd0 : r_h + 10'd1;
        v_nxt   = r_v;
        if (h_wrap)
            v_nxt = (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
        vbl_set = h_wrap && (v_nxt == V_ACT);
        vbl_clr = h_wrap && (v_nxt == 10'd0);
        // Swap only at the start of vblank so a bank never changes mid-picture.
        swap    = i_pix_ce && vbl_set && (r_pend || i_wr_done);
        win     = (r_v < V_ACT) && (r_h >= WIN_BEG) && (r_h < WIN_END);
        de0     = (r_h < H_ACT) && (r_v < V_ACT);
        hs0     = !((r_h >= HS_BEG) && (r_h < HS_END));
        vs0     = !((r_v >= VS_BEG) && (r_v < VS_END));
    end

    assign o_wr_bank = ~r_rd_bank;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_h          <= '0;
            r_v          <= '0;
            r_rd_bank    <= 1'b0;
            r_pend       <= 1'b0;
            o_vblank     <= 1'b0;
            o_vbuf_raddr <= '0;
            s1_win       <= 1'b0;
            s1_de        <= 1'b0;
            s1_hs        <= 1'b1;
            s1_vs        <= 1'b1;
            o_pix        <= '0;
            o_de         <= 1'b0;
            o_hsync      <= 1'b1;
            o_vsync      <= 1'b1;
        end else begin
            if (swap)
                r_pend <= 1'b0;
            else if (i_wr_done)
                r_pend <= 1'b1;

            if (i_pix_ce) begin
                r_h <= h_nxt;
                r_v <= v_nxt;
                if (swap)
                    r_rd_bank <= ~r_rd_bank;
                if (vbl_set)
                    o_vblank <= 1'b1;
                else if (vbl_clr)
                    o_vblank <= 1'b0;

                if (win)
                    o_vbuf_raddr <= {r_rd_bank, 8'(r_v >> 1), 8'((r_h - WIN_BEG) >> 1)};
                s1_win <= win;
                s1_de  <= de0;
                s1_hs  <= hs0;
                s1_vs  <= vs0;

                o_pix   <= s1_win ? i_vbuf_rdata : BORDER;
                o_de    <= s1_de;
                o_hsync <= s1_hs;
                o_vsync <= s1_vs;
            end
        end
    end

endmodule

// File: tb/tb_ppu_vscan.sv
// Scoreboard bench for ppu_vscan with a shortened vertical timing so several frames fit
// in a short run; horizontal timing and the picture window are the real ones.
`timescale 1ns/1ps
module tb_ppu_vscan;

    localparam int H_TOT = 800;
    localparam int V_ACT = 4;
    localparam int V_FP  = 1;
    localparam int V_SYN = 1;
    localparam int V_BP  = 1;
    localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int VSET  = V_ACT * H_TOT;
    localparam logic [7:0] BORDER = 8'h0F;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pix_ce = 1'b0;
    logic        wr_done = 1'b0;
    logic        wr_bank, vblank, de, hsync, vsync;
    logic [16:0] raddr;
    logic [7:0]  rdata = 8'h00;
    logic [7:0]  pix;

    always #5 clk = ~clk;

    ppu_vscan #(.V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYN), .V_BP(V_BP)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_pix_ce(pix_ce), .i_wr_done(wr_done),
        .o_wr_bank(wr_bank), .o_vblank(vblank), .o_vbuf_raddr(raddr),
        .i_vbuf_rdata(rdata), .o_pix(pix), .o_de(de), .o_hsync(hsync), .o_vsync(vsync)
    );

    // Frame buffer contents: x ^ y, with bank 1 marked so the bank in use is visible on o_pix.
    function automatic logic [7:0] ram_data(input bit b, input int y, input int x);
        return 8'(x ^ y) ^ (b ? 8'h5A : 8'h00);
    endfunction

    always @(posedge clk) rdata <= ram_data(raddr[16], int'(raddr[15:8]), int'(raddr[7:0]));

    typedef struct {
        logic [7:0]  pix;
        logic        de, hs, vs, win;
        logic [16:0] addr;
    } srec_t;

    typedef struct {
        logic [7:0]  pix;
        logic        de, hs, vs, vbl, wrb;
        logic [16:0] addr;
        bit          pix_chk;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    int          p, gap;
    bit          bank, pend, o_pixok;
    srec_t       s1, o;
    logic [16:0] addr;

    // What the screen should show at raster position pp when reading bank b.
    function automatic srec_t pos_rec(input int pp, input bit b);
        srec_t r;
        int h = pp % H_TOT;
        int v = pp / H_TOT;
        r.win  = (v < V_ACT) && (h >= 64) && (h < 576);
        r.de   = (h < 640) && (v < V_ACT);
        r.hs   = !((h >= 656) && (h < 752));
        r.vs   = !((v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SYN));
        r.pix  = r.win ? ram_data(b, v / 2, (h - 64) / 2) : BORDER;
        r.addr = {b, 8'(v / 2), 8'((h - 64) / 2)};
        return r;
    endfunction

    task automatic model_reset();
        p = 0; bank = 1'b0; pend = 1'b0; addr = '0; gap = 100;
        s1 = '{pix: BORDER, de: 1'b0, hs: 1'b1, vs: 1'b1, win: 1'b0, addr: 17'd0};
        o  = '{pix: 8'h00,  de: 1'b0, hs: 1'b1, vs: 1'b1, win: 1'b0, addr: 17'd0};
        o_pixok = 1'b1;
    endtask

    task automatic model_step(input bit ce, input bit wd);
        srec_t cur;
        int np;
        gap++;
        if (ce) begin
            o       = s1;
            o_pixok = !s1.win || (gap >= 2);
            cur     = pos_rec(p, bank);
            if (cur.win) addr = cur.addr;
            s1  = cur;
            gap = 0;
            np  = (p + 1) % FRAME;
            if (np == VSET && (pend || wd)) begin
                bank = !bank;
                pend = 1'b0;
            end else if (wd) begin
                pend = 1'b1;
            end
            p = np;
        end else if (wd) begin
            pend = 1'b1;
        end
    endtask

    function automatic exp_t cur_exp();
        exp_t e;
        e.pix = o.pix; e.de = o.de; e.hs = o.hs; e.vs = o.vs;
        e.vbl = (p / H_TOT) >= V_ACT;
        e.wrb = !bank;
        e.addr = addr;
        e.pix_chk = o_pixok;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("de", 17'(de), 17'(e.de));
                chk("hsync", 17'(hsync), 17'(e.hs));
                chk("vsync", 17'(vsync), 17'(e.vs));
                chk("vblank", 17'(vblank), 17'(e.vbl));
                chk("wr_bank", 17'(wr_bank), 17'(e.wrb));
                chk("raddr", raddr, e.addr);
                if (e.pix_chk) chk("pix", 17'(pix), 17'(e.pix));
            end
        end
    end

    task automatic cycle(input bit ce, input bit wd);
        pix_ce  = ce;
        wr_done = wd;
        @(posedge clk);
        if (!rstn) model_reset();
        else       model_step(ce, wd);
        q.push_back(cur_exp());
        #1;
    endtask

    task automatic ce_step(input bit wd, input int g);
        cycle(1'b1, wd);
        repeat (g - 1) cycle(1'b0, 1'b0);
    endtask

    task automatic run_to(input int target, input int g);
        int n = 0;
        while (p != target && n <= FRAME) begin
            ce_step(1'b0, g);
            n++;
        end
        if (p != target) begin
            miscompares++;
            $display("FAIL run_to timeout: position %0d expected %0d", p, target);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("rst_pix", 17'(pix), 17'd0);
        chk("rst_de", 17'(de), 17'd0);
        chk("rst_hsync", 17'(hsync), 17'd1);
        chk("rst_vsync", 17'(vsync), 17'd1);
        chk("rst_vblank", 17'(vblank), 17'd0);
        chk("rst_wr_bank", 17'(wr_bank), 17'd1);
        chk("rst_raddr", raddr, 17'd0);
        model_reset();
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        model_reset();
        repeat (3) cycle(1'b0, 1'b0);
        rstn = 1'b1;

        // ce always high: timing, then the bank-swap cases at each vblank
        run_to(1000, 1);
        cycle(1'b0, 1'b1);
        run_to(VSET - 1, 1);
        ce_step(1'b0, 1);
        run_to(VSET - 1, 1);
        ce_step(1'b0, 1);
        run_to(VSET - 1, 1);
        ce_step(1'b1, 1);
        run_to(VSET - 1, 1);
        ce_step(1'b0, 1);
        ce_step(1'b1, 1);
        run_to(VSET - 1, 1);
        ce_step(1'b0, 1);

        // ce 1-of-2: full visible area with pixel data checked
        run_to(0, 2);
        run_to(1500, 2);
        cycle(1'b0, 1'b1);
        run_to(VSET + 10, 2);

        // ce 1-of-4
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                cycle(1'b1, 1'b0);
                cycle(1'b0, 1'b1);
                repeat (2) cycle(1'b0, 1'b0);
            end else begin
                ce_step(1'b0, 4);
            end
        end

        // random ce spacing with random writer pulses
        for (int i = 0; i < 3000; i++) begin
            cycle(1'b1, $urandom_range(0, 299) == 0);
            repeat ($urandom_range(1, 3)) cycle(1'b0, $urandom_range(0, 299) == 0);
        end

        // reset in the middle of a visible line, then restart from h=0, v=0
        run_to(2 * H_TOT + 300, 1);
        do_reset();
        repeat (2) cycle(1'b0, 1'b0);
        rstn = 1'b1;
        for (int i = 0; i < 1000; i++) ce_step(1'b0, 1);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard: %0d expectations left unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
